// File: rtl/dmem_mmio_responder.sv
// Data-side memory responder for the core's M stage: word RAM plus an MMIO block
// with a free-running cycle counter, a compare timer and a 4-entry TX byte FIFO.
module dmem_mmio_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwriteM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic [7:0]  io_data,
  output logic        io_valid,
  input  logic        io_ready,
  output logic        timer_irq
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [29:0] A_CYCLE  = 30'h3FFF_C000;
  localparam logic [29:0] A_TCMP   = 30'h3FFF_C001;
  localparam logic [29:0] A_STATUS = 30'h3FFF_C002;
  localparam logic [29:0] A_TXDATA = 30'h3FFF_C003;

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [7:0]  r_fifo [4];

  logic [31:0] r_cycle;
  logic [31:0] r_tcmp;
  logic        r_timer_hit;
  logic        r_overflow;
  logic [1:0]  r_rd_ptr;
  logic [1:0]  r_wr_ptr;
  logic [2:0]  r_count;

  logic [29:0]   w_word;
  logic [AW-1:0] w_ram_idx;
  logic          w_is_ram;
  logic          w_store;
  logic          w_wr_tcmp;
  logic          w_wr_status;
  logic          w_wr_tx;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_overflow;
  logic          w_cycle_hit;
  logic          w_unused_addr_lsbs;

  assign w_unused_addr_lsbs = ^aluoutM[1:0];

  assign w_word    = aluoutM[31:2];
  assign w_ram_idx = aluoutM[AW+1:2];
  assign w_is_ram  = (aluoutM[31:AW+2] == '0);

  // A store in a reset cycle must not land anywhere, including the RAM.
  assign w_store     = memwriteM && !reset;
  assign w_wr_tcmp   = w_store && (w_word == A_TCMP);
  assign w_wr_status = w_store && (w_word == A_STATUS);
  assign w_wr_tx     = w_store && (w_word == A_TXDATA);

  assign w_full      = (r_count == 3'(FIFO_DEPTH));
  assign w_empty     = (r_count == 3'd0);
  assign w_pop       = !w_empty && io_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign w_push      = w_wr_tx && (!w_full || w_pop);
  assign w_overflow  = w_wr_tx && w_full && !w_pop;
  assign w_cycle_hit = (r_cycle == r_tcmp);

  assign io_valid  = !w_empty;
  assign io_data   = w_empty ? 8'h00 : r_fifo[r_rd_ptr];
  assign timer_irq = r_timer_hit;

  // NOTE: RAM and FIFO storage are deliberately left out of reset; only the
  // control state that gives them meaning (pointers, count) is reset.
  always_ff @(posedge clk) begin
    if (w_store && w_is_ram) r_mem[w_ram_idx] <= writedataM;
    if (w_push)              r_fifo[r_wr_ptr] <= writedataM[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle     <= '0;
      r_tcmp      <= 32'hFFFF_FFFF;
      r_timer_hit <= 1'b0;
      r_overflow  <= 1'b0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;

      if (w_wr_tcmp) r_tcmp <= writedataM;

      if (w_cycle_hit)                      r_timer_hit <= 1'b1;
      else if (w_wr_status && writedataM[2]) r_timer_hit <= 1'b0;

      if (w_overflow)                       r_overflow <= 1'b1;
      else if (w_wr_status && writedataM[3]) r_overflow <= 1'b0;

      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the default assignment first keeps this purely combinational;
  // without it an unmatched address would infer a latch.
  always_comb begin
    readdataM = '0;
    if (w_is_ram) begin
      readdataM = r_mem[w_ram_idx];
    end else if (w_word == A_CYCLE) begin
      readdataM = r_cycle;
    end else if (w_word == A_TCMP) begin
      readdataM = r_tcmp;
    end else if (w_word == A_STATUS) begin
      readdataM = {25'd0, r_count, r_overflow, r_timer_hit, w_empty, w_full};
    end
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: the driver queues expectations tagged
// with a cycle number, a negedge monitor compares them and scores FIFO pops.
module tb_dmem_mmio_responder;

  localparam logic [31:0] CYCLE_A  = 32'hFFFF_0000;
  localparam logic [31:0] TCMP_A   = 32'hFFFF_0004;
  localparam logic [31:0] STATUS_A = 32'hFFFF_0008;
  localparam logic [31:0] TXDATA_A = 32'hFFFF_000C;
  localparam logic [31:0] IDLE_A   = 32'hFFFF_0010;

  typedef enum int {K_RD, K_IRQ, K_VALID, K_DATA} kind_e;

  typedef struct {
    int          cyc;
    kind_e       kind;
    logic [31:0] want;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwriteM = 1'b0;
  logic [31:0] aluoutM = 32'h0;
  logic [31:0] writedataM = 32'h0;
  logic [31:0] readdataM;
  logic [7:0]  io_data;
  logic        io_valid;
  logic        io_ready = 1'b0;
  logic        timer_irq;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pops  = 0;
  int cyc     = 0;

  exp_t        chk_q[$];
  logic [7:0]  byte_q[$];

  dmem_mmio_responder #(.DEPTH_WORDS(256), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .memwriteM  (memwriteM),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .readdataM  (readdataM),
    .io_data    (io_data),
    .io_valid   (io_valid),
    .io_ready   (io_ready),
    .timer_irq  (timer_irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
    end
  endtask

  task automatic exp_at(input kind_e kind, input string name, input logic [31:0] want);
    exp_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.want = want;
    e.name = name;
    chk_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    memwriteM  = 1'b0;
    aluoutM    = IDLE_A;
    writedataM = 32'h0;
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic rdy);
    memwriteM  = we;
    aluoutM    = addr;
    writedataM = wd;
    io_ready   = rdy;
  endtask

  task automatic goto_cycle(input int n);
    while (cyc < n) step();
  endtask

  // Monitor: scheduled expectations, FIFO pop scoreboard, and hold-while-stalled.
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic       prev_reset = 1'b1;
  logic [7:0] prev_data  = 8'h0;

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (chk_q.size() > 0 && chk_q[0].cyc == cyc) begin
      e = chk_q.pop_front();
      case (e.kind)
        K_RD:    act = readdataM;
        K_IRQ:   act = {31'd0, timer_irq};
        K_VALID: act = {31'd0, io_valid};
        default: act = {24'd0, io_data};
      endcase
      check(e.name, act, e.want);
    end

    if (!prev_reset && prev_valid && !prev_ready) begin
      check("hold_valid", {31'd0, io_valid}, 32'd1);
      check("hold_data", {24'd0, io_data}, {24'd0, prev_data});
    end

    if (!reset && io_valid && io_ready) begin
      n_pops++;
      if (byte_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pop_extra: got byte 0x%02h, expected no further pop", io_data);
      end else begin
        check("pop_order", {24'd0, io_data}, {24'd0, byte_q.pop_front()});
      end
    end

    prev_valid = io_valid;
    prev_ready = io_ready;
    prev_reset = reset;
    prev_data  = io_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] fill [5];
    logic [7:0] held [4];
    fill = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    held = '{8'h33, 8'h44, 8'h66, 8'h00};

    reset = 1'b1;
    drive(1'b0, IDLE_A, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // cycle 0: reset state
    drive(1'b0, CYCLE_A, 32'h0, 1'b0);
    exp_at(K_RD, "cycle_at_0", 32'd0);
    exp_at(K_VALID, "rst_valid", 32'd0);
    exp_at(K_DATA, "rst_data", 32'd0);
    exp_at(K_IRQ, "rst_irq", 32'd0);
    step(); drive(1'b0, STATUS_A, 32'h0, 1'b0); exp_at(K_RD, "rst_status", 32'h2);
    step(); drive(1'b0, TCMP_A, 32'h0, 1'b0);   exp_at(K_RD, "rst_tcmp", 32'hFFFF_FFFF);

    // RAM round trip and address decode
    step(); drive(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    step(); drive(1'b0, 32'h10, 32'h0, 1'b0);    exp_at(K_RD, "ram_0x10", 32'hDEAD_BEEF);
    step(); drive(1'b1, TCMP_A, 32'd20, 1'b0);   // cycle 5
    step(); drive(1'b0, 32'h13, 32'h0, 1'b0);    exp_at(K_RD, "ram_0x13", 32'hDEAD_BEEF);
    step(); drive(1'b0, 32'h4000, 32'h0, 1'b0);  exp_at(K_RD, "ram_oob", 32'h0);
    step(); drive(1'b0, TXDATA_A, 32'h0, 1'b0);  exp_at(K_RD, "txdata_rd", 32'h0);
    step(); drive(1'b0, TCMP_A, 32'h0, 1'b0);    exp_at(K_RD, "tcmp_rd", 32'd20);
    step(); drive(1'b0, IDLE_A, 32'h0, 1'b0);    exp_at(K_RD, "unmapped_rd", 32'h0);
    step(); drive(1'b1, CYCLE_A, 32'h1234, 1'b0);
    step(); drive(1'b0, CYCLE_A, 32'h0, 1'b0);   exp_at(K_RD, "cycle_at_12", 32'd12);

    // compare timer
    goto_cycle(20);
    drive(1'b0, STATUS_A, 32'h0, 1'b0);
    exp_at(K_IRQ, "irq_c20", 32'd0);
    exp_at(K_RD, "status_c20", 32'h2);
    step(); drive(1'b0, STATUS_A, 32'h0, 1'b0);
    exp_at(K_IRQ, "irq_c21", 32'd1);
    exp_at(K_RD, "status_c21", 32'h6);
    step(); exp_at(K_IRQ, "irq_c22", 32'd1);
    step(); drive(1'b1, STATUS_A, 32'h4, 1'b0); exp_at(K_IRQ, "irq_c23", 32'd1);
    step(); drive(1'b0, STATUS_A, 32'h0, 1'b0);
    exp_at(K_IRQ, "irq_cleared", 32'd0);
    exp_at(K_RD, "status_cleared", 32'h2);
    step(); exp_at(K_IRQ, "irq_stays_clear", 32'd0);

    // FIFO fill past capacity with the consumer stalled
    goto_cycle(30);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, TXDATA_A, {24'd0, fill[i]}, 1'b0);
      if (i < 4) byte_q.push_back(fill[i]);
      if (i == 0) exp_at(K_VALID, "valid_same_cycle", 32'd0);
      if (i == 1) begin
        exp_at(K_VALID, "valid_next_cycle", 32'd1);
        exp_at(K_DATA, "head_first", 32'h11);
      end
      step();
    end
    drive(1'b0, STATUS_A, 32'h0, 1'b0);
    exp_at(K_RD, "status_full_ovf", 32'h49);
    exp_at(K_DATA, "head_after_fill", 32'h11);

    // full FIFO: push with simultaneous pop
    step(); drive(1'b1, TXDATA_A, 32'h66, 1'b1);
    byte_q.push_back(8'h66);
    step(); drive(1'b1, STATUS_A, 32'h8, 1'b0);
    exp_at(K_DATA, "head_after_pop", 32'h22);
    step(); drive(1'b0, STATUS_A, 32'h0, 1'b0);
    exp_at(K_RD, "status_full_no_ovf", 32'h41);

    // drain with io_ready toggling every cycle
    for (int k = 0; k < 8; k++) begin
      step();
      drive(1'b0, IDLE_A, 32'h0, (k % 2) == 0);
      if ((k % 2) == 1) exp_at(K_DATA, "drain_head", {24'd0, held[k/2]});
      if (k == 7) exp_at(K_VALID, "drained_valid", 32'd0);
    end
    step(); drive(1'b0, STATUS_A, 32'h0, 1'b0);
    exp_at(K_RD, "status_drained", 32'h2);

    // reset in the middle of traffic
    goto_cycle(50);
    drive(1'b1, TCMP_A, 32'd5, 1'b0);
    step(); drive(1'b1, TXDATA_A, 32'hA1, 1'b0);
    step(); drive(1'b1, TXDATA_A, 32'hA2, 1'b0);
    step(); drive(1'b1, TXDATA_A, 32'hA3, 1'b0);
    step(); drive(1'b0, STATUS_A, 32'h0, 1'b0);
    exp_at(K_RD, "status_three", 32'h30);
    exp_at(K_DATA, "head_three", 32'hA1);
    step();
    reset = 1'b1;
    drive(1'b1, TXDATA_A, 32'hA4, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b0, CYCLE_A, 32'h0, 1'b0);
    exp_at(K_RD, "post_rst_cycle", 32'd0);
    exp_at(K_VALID, "post_rst_valid", 32'd0);
    exp_at(K_DATA, "post_rst_data", 32'd0);
    exp_at(K_IRQ, "post_rst_irq", 32'd0);
    step(); drive(1'b0, STATUS_A, 32'h0, 1'b0);
    exp_at(K_RD, "post_rst_status", 32'h2);
    exp_at(K_VALID, "post_rst_valid_c1", 32'd0);
    step(); drive(1'b0, TCMP_A, 32'h0, 1'b0);
    exp_at(K_RD, "post_rst_tcmp", 32'hFFFF_FFFF);
    exp_at(K_VALID, "post_rst_valid_c2", 32'd0);
    step(); drive(1'b0, 32'h10, 32'h0, 1'b0);
    exp_at(K_RD, "ram_survives_rst", 32'hDEAD_BEEF);
    step();
    step();

    check("chk_q_drained", chk_q.size(), 32'd0);
    check("byte_q_drained", byte_q.size(), 32'd0);
    check("pop_count", n_pops, 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
